// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory / MMIO responder: page select,
// register offsets, byte-lane indices and the UART state encoding.
package dmem_mmio_responder_pkg;

    localparam logic [15:0] MMIO_PAGE    = 16'hFFFF;

    localparam logic [15:0] OFF_LED      = 16'h0000;
    localparam logic [15:0] OFF_CYCLE    = 16'h0004;
    localparam logic [15:0] OFF_UART_TX  = 16'h0008;
    localparam logic [15:0] OFF_UART_DIV = 16'h000C;

    // Big-endian lanes: byte offset 0 lives in bits 31:24, driven by we[3].
    localparam int LANE_BYTE0 = 3;
    localparam int LANE_BYTE1 = 2;
    localparam int LANE_BYTE2 = 1;
    localparam int LANE_BYTE3 = 0;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

    function automatic logic [15:0] eff_period(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_uart_tx_core.sv
// 8N1 serial transmitter; bit period is latched when a frame starts so a
// divisor change mid-frame only affects the following frame.
module uart_tx_core
    import dmem_mmio_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  data,
    input  logic [15:0] div,
    output logic        tx,
    output logic        busy
);

    uart_state_e state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [15:0] period_q, period_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        slot_done;

    assign slot_done = (baud_q == (period_q - 16'd1));
    assign tx        = tx_q;
    assign busy      = busy_q;

    // tx_d is the level for the slot that begins on the coming edge, so the
    // line changes exactly on slot boundaries straight from a flop.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        period_d = period_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        case (state_q)
            UART_IDLE: begin
                if (load) begin
                    state_d  = UART_START;
                    period_d = eff_period(div);
                    baud_d   = 16'd0;
                    bit_d    = 3'd0;
                    shift_d  = data;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            UART_START: begin
                if (slot_done) begin
                    state_d = UART_DATA;
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            UART_DATA: begin
                if (slot_done) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_d];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            UART_STOP: begin
                if (slot_done) begin
                    state_d = UART_IDLE;
                    baud_d  = 16'd0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = UART_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= UART_IDLE;
            baud_q   <= 16'd0;
            period_q <= 16'd1;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            period_q <= period_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus an MMIO page
// holding LED, free-running cycle counter and a UART transmitter.
module dmem_mmio_responder
    import dmem_mmio_responder_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    output logic [31:0] rdata,
    output logic [7:0]  led,
    output logic        uart_tx,
    output logic        uart_busy
);

    logic [31:0]       ram_q [2**ADDR_W];
    logic [ADDR_W-1:0] ram_idx;
    logic              mmio_sel;
    logic [15:0]       page_off;
    logic              sel_led, sel_cycle, sel_tx, sel_div;
    logic [7:0]        led_q, led_d;
    logic [31:0]       cycle_q, cycle_d;
    logic [15:0]       div_q, div_d;
    logic              uart_load;
    logic              unused_addr;

    // The byte offset within a word is carried by the lane enables instead.
    assign unused_addr = ^addr[1:0];

    assign mmio_sel  = (addr[31:16] == MMIO_PAGE);
    assign ram_idx   = addr[ADDR_W+1:2];
    assign page_off  = {addr[15:2], 2'b00};
    assign sel_led   = mmio_sel && (page_off == OFF_LED);
    assign sel_cycle = mmio_sel && (page_off == OFF_CYCLE);
    assign sel_tx    = mmio_sel && (page_off == OFF_UART_TX);
    assign sel_div   = mmio_sel && (page_off == OFF_UART_DIV);
    assign uart_load = sel_tx && we[LANE_BYTE3];
    assign led       = led_q;

    always_ff @(posedge clk) begin
        if (!mmio_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    ram_q[ram_idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        led_d   = led_q;
        div_d   = div_q;
        cycle_d = cycle_q + 32'd1;
        if (sel_led && we[LANE_BYTE3]) begin
            led_d = wdata[7:0];
        end
        if (sel_div && we[LANE_BYTE2]) begin
            div_d[15:8] = wdata[15:8];
        end
        if (sel_div && we[LANE_BYTE3]) begin
            div_d[7:0] = wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q   <= 8'd0;
            cycle_q <= 32'd0;
            div_q   <= DIV_DEFAULT;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        rdata = ram_q[ram_idx];
        if (mmio_sel) begin
            rdata = 32'd0;
            if (sel_led)   rdata = {24'd0, led_q};
            if (sel_cycle) rdata = cycle_q;
            if (sel_tx)    rdata = {31'd0, uart_busy};
            if (sel_div)   rdata = {16'd0, div_q};
        end
    end

    uart_tx_core u_uart_tx_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (uart_load),
        .data  (wdata[7:0]),
        .div   (div_q),
        .tx    (uart_tx),
        .busy  (uart_busy)
    );

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Self-checking bench for dmem_mmio_responder: a frame-level behavioural model
// compared every cycle, plus directed reads with hand-computed values.
module tb_dmem_mmio_responder;

    localparam int ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  we = 4'd0;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic        uart_tx;
    logic        uart_busy;

    int checks = 0;
    int fails  = 0;
    bit cmp_en = 1'b0;

    dmem_mmio_responder #(.ADDR_W(ADDR_W), .DIV_DEFAULT(16'd434)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .rdata     (rdata),
        .led       (led),
        .uart_tx   (uart_tx),
        .uart_busy (uart_busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: registers as plain variables, the UART as
    // "frame started at edge t0 with period P and byte D".
    logic [31:0] m_ram [int];
    logic [7:0]  m_led;
    logic [31:0] m_cycle;
    logic [15:0] m_div;
    longint      m_edges, m_t0, m_period;
    bit          m_active;
    logic [7:0]  m_data;

    function automatic bit m_busy();
        return m_active && ((m_edges - m_t0) < 10 * m_period);
    endfunction

    function automatic bit m_tx();
        int slot;
        logic [2:0] bi;
        if (!m_busy()) return 1'b1;
        slot = int'((m_edges - m_t0) / m_period);
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        bi = 3'(slot - 1);
        return m_data[bi];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int idx;
        if (a[31:16] == 16'hFFFF) begin
            case ({a[15:2], 2'b00})
                16'h0000: return {24'd0, m_led};
                16'h0004: return m_cycle;
                16'h0008: return {31'd0, m_busy()};
                16'h000C: return {16'd0, m_div};
                default:  return 32'd0;
            endcase
        end
        idx = int'(a[ADDR_W+1:2]);
        return m_ram.exists(idx) ? m_ram[idx] : 32'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit b;
        int idx;
        logic [31:0] w;
        if (!rst_n) begin
            m_led    = 8'd0;
            m_cycle  = 32'd0;
            m_div    = 16'd434;
            m_active = 1'b0;
            m_edges  = 0;
            m_t0     = 0;
            m_period = 1;
            m_data   = 8'd0;
        end else begin
            b = m_busy();
            if (addr[31:16] == 16'hFFFF) begin
                case ({addr[15:2], 2'b00})
                    16'h0000: if (we[0]) m_led = wdata[7:0];
                    16'h0008: if (we[0] && !b) begin
                        m_active = 1'b1;
                        m_t0     = m_edges + 1;
                        m_period = (m_div == 16'd0) ? 1 : longint'(m_div);
                        m_data   = wdata[7:0];
                    end
                    16'h000C: begin
                        if (we[1]) m_div[15:8] = wdata[15:8];
                        if (we[0]) m_div[7:0]  = wdata[7:0];
                    end
                    default: ;
                endcase
            end else if (we != 4'd0) begin
                idx = int'(addr[ADDR_W+1:2]);
                w = m_ram.exists(idx) ? m_ram[idx] : 32'd0;
                for (int i = 0; i < 4; i++) begin
                    if (we[i]) w[i*8 +: 8] = wdata[i*8 +: 8];
                end
                m_ram[idx] = w;
            end
            m_cycle = m_cycle + 32'd1;
            m_edges = m_edges + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = w;
    endtask

    task automatic readLit(input string name, input logic [31:0] a, input logic [31:0] lit);
        applyStimulus(a, 32'd0, 4'd0);
        #1;
        checkOutput({name, "_model"}, rdata, m_read(a));
        checkOutput(name, rdata, lit);
    endtask

    task automatic countBusy(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) begin
                addr = 32'd0;
                wdata = 32'd0;
                we = 4'd0;
            end
            if (uart_busy) cnt++;
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("cyc_tx",   32'(uart_tx),   32'(m_tx()));
            checkOutput("cyc_busy", 32'(uart_busy), 32'(m_busy()));
            checkOutput("cyc_led",  32'(led),       32'(m_led));
        end
    end

    initial begin
        logic [31:0] v1, v2;
        int cnt;
        bit tx_seen [10];
        bit exp_slots [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        $display("[TB] reset values");
        readLit("led_reset", 32'hFFFF0000, 32'h00000000);
        readLit("div_reset", 32'hFFFF000C, 32'h000001B2);
        checkOutput("tx_reset",   32'(uart_tx),   32'd1);
        checkOutput("busy_reset", 32'(uart_busy), 32'd0);

        $display("[TB] RAM lanes, aliasing, read-during-write");
        applyStimulus(32'h00000010, 32'h11223344, 4'b1111);
        applyStimulus(32'h00000010, 32'h00AA0000, 4'b0100);
        readLit("ram_merge", 32'h00000010, 32'h11AA3344);
        readLit("ram_alias", 32'h00001010, 32'h11AA3344);
        applyStimulus(32'h00000010, 32'hDEADBEEF, 4'b1111);
        #1;
        checkOutput("ram_old_on_write", rdata, 32'h11AA3344);
        readLit("ram_new", 32'h00000010, 32'hDEADBEEF);
        applyStimulus(32'h00000FFC, 32'hCAFEF00D, 4'b1111);
        readLit("ram_top_alias", 32'h00007FFC, 32'hCAFEF00D);
        readLit("ram_untouched", 32'h00000010, 32'hDEADBEEF);

        $display("[TB] cycle counter");
        applyStimulus(32'hFFFF0004, 32'd0, 4'd0);
        #1;
        v1 = rdata;
        checkOutput("cycle_model_1", v1, m_read(32'hFFFF0004));
        repeat (7) @(negedge clk);
        #1;
        v2 = rdata;
        checkOutput("cycle_delta", v2 - v1, 32'd7);
        applyStimulus(32'hFFFF0004, 32'h12345678, 4'b1111);
        #1;
        checkOutput("cycle_model_2", rdata, m_read(32'hFFFF0004));
        applyStimulus(32'hFFFF0004, 32'd0, 4'd0);
        #1;
        checkOutput("cycle_write_ignored", rdata, m_read(32'hFFFF0004));
        force dut.cycle_q = 32'hFFFFFFFF;
        m_cycle = 32'hFFFFFFFF;
        #1;
        checkOutput("cycle_forced", rdata, 32'hFFFFFFFF);
        release dut.cycle_q;
        @(negedge clk);
        #1;
        checkOutput("cycle_wrap", rdata, 32'h00000000);
        checkOutput("cycle_wrap_model", rdata, m_read(32'hFFFF0004));

        $display("[TB] MMIO holes and LED lanes");
        applyStimulus(32'hFFFF0020, 32'hFFFFFFFF, 4'b1111);
        readLit("mmio_hole", 32'hFFFF0020, 32'h00000000);
        readLit("div_unchanged", 32'hFFFF000C, 32'h000001B2);
        applyStimulus(32'hFFFF0000, 32'h0000005A, 4'b0001);
        readLit("led_write", 32'hFFFF0000, 32'h0000005A);
        checkOutput("led_port", 32'(led), 32'h5A);
        applyStimulus(32'hFFFF0000, 32'hFFFFFFFF, 4'b1110);
        readLit("led_masked", 32'hFFFF0000, 32'h0000005A);

        $display("[TB] UART frame, DIV=4, byte 0xA5");
        applyStimulus(32'hFFFF000C, 32'h00000004, 4'b0011);
        readLit("div_set", 32'hFFFF000C, 32'h00000004);
        applyStimulus(32'hFFFF0008, 32'h000000A5, 4'b0001);
        cnt = 0;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            if (k == 0 || k == 13 || k == 21) begin
                addr = 32'd0;
                wdata = 32'd0;
                we = 4'd0;
            end
            if (k == 12) begin
                addr = 32'hFFFF0008;
                wdata = 32'h0000003C;
                we = 4'b0001;
            end
            if (k == 20) begin
                addr = 32'hFFFF000C;
                wdata = 32'h00000002;
                we = 4'b0011;
            end
            if (k == 30) begin
                addr = 32'hFFFF0008;
            end
            if (uart_busy) cnt++;
            if ((k % 4) == 2 && (k / 4) < 10) tx_seen[k / 4] = uart_tx;
        end
        checkOutput("busy_len_div4", cnt, 32'd40);
        for (int s = 0; s < 10; s++) begin
            checkOutput($sformatf("tx_slot%0d", s), 32'(tx_seen[s]), 32'(exp_slots[s]));
        end
        readLit("div_next_frame", 32'hFFFF000C, 32'h00000002);

        $display("[TB] UART frame, DIV=0");
        applyStimulus(32'hFFFF000C, 32'h00000000, 4'b0011);
        applyStimulus(32'hFFFF0008, 32'h00000000, 4'b0001);
        countBusy(14, cnt);
        checkOutput("busy_len_div0", cnt, 32'd10);

        $display("[TB] reset mid-frame");
        applyStimulus(32'hFFFF0008, 32'h00000081, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                addr = 32'd0;
                wdata = 32'd0;
                we = 4'd0;
            end
        end
        @(negedge clk);
        checkOutput("busy_before_abort", 32'(uart_busy), 32'd1);
        checkOutput("tx_before_abort",   32'(uart_tx),   32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("tx_abort",   32'(uart_tx),   32'd1);
        checkOutput("busy_abort", 32'(uart_busy), 32'd0);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        readLit("led_after_reset", 32'hFFFF0000, 32'h00000000);
        readLit("div_after_reset", 32'hFFFF000C, 32'h000001B2);
        applyStimulus(32'hFFFF0008, 32'h00000055, 4'b0001);
        @(negedge clk);
        addr = 32'd0;
        wdata = 32'd0;
        we = 4'd0;
        checkOutput("load_after_reset", 32'(uart_busy), 32'd1);
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder for the single-cycle MIPS core's data-memory port. Answers the core's load/store address, write data and 4-bit byte-lane write enables.
- Contains a word-organised data RAM and a small memory-mapped I/O page: LED register, free-running cycle counter, UART transmitter with programmable baud divisor.
- Read data is combinational, because the core completes a load in one cycle. All state changes occur on the rising edge of clk.

Parameters:
- ADDR_W, 10: RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
- DIV_DEFAULT, 16'd434: UART bit period in clk cycles after reset.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- addr  input  32  byte address from the core's ALU result
- wdata  input  32  store data, already lane-aligned by the core
- we  input  4  byte-lane write enables, big-endian: we[3]->bits 31:24 (byte offset 0) ... we[0]->bits 7:0 (byte offset 3)
- rdata  output  32  combinational read data
- led  output  8  LED register
- uart_tx  output  1  serial line, idles high
- uart_busy  output  1  high while a frame is in progress

Behaviour:
- Decode:
  - addr[31:16]==16'hFFFF selects MMIO.
  - Any other address selects RAM at word index addr[ADDR_W+1:2]. Upper bits are ignored, so addresses alias/wrap.
  - addr[1:0] is ignored for decode; lanes are carried by we.
- RAM:
  - On the clk edge, each lane with we[i]=1 writes the matching byte of wdata.
  - rdata = array[index] combinationally. Reading the same word in the cycle it is written returns the old value.
  - RAM is not reset; contents are undefined until written.
- MMIO map (word offsets within the page):
  - 0x0 LED: read/write. we[0] writes led<=wdata[7:0]. Reads return {24'b0,led}.
  - 0x4 CYCLE: read-only 32-bit counter. Increments every clk, wraps 0xFFFFFFFF->0. Writes are ignored.
  - 0x8 UART_TX:
    - A write with we[0]=1 while uart_busy=0 loads wdata[7:0] and starts a frame.
    - A write while busy is silently dropped.
    - Reads return {31'b0,uart_busy}.
  - 0xC UART_DIV: read/write 16-bit. we[1] writes bits 15:8, we[0] writes bits 7:0. Reads return {16'b0,div}.
  - Other MMIO offsets: reads return 0, writes are ignored.
- UART transmitter FSM, states IDLE, START, DATA, STOP:
  - Effective bit period P = (div==0) ? 1 : div cycles. P is sampled at frame start and held for the whole frame.
  - IDLE: uart_tx=1, uart_busy=0. A load moves to START on that edge; busy asserts the same edge.
  - START: tx=0 for P cycles.
  - DATA: 8 bits, LSB first, each held for P cycles. A 3-bit bit counter and a 16-bit baud counter are used.
  - STOP: tx=1 for P cycles, then IDLE and busy deasserts.
  - Frame length is exactly 10*P cycles from the load edge to the busy fall.
  - A new load is accepted in the cycle after busy falls.
  - uart_tx is registered and glitch-free.
- Simultaneous events:
  - A DIV write during a frame takes effect on the next frame only.
  - A CYCLE read returns the pre-edge value.
- Reset values: led=0, CYCLE=0, div=DIV_DEFAULT, uart_tx=1, uart_busy=0, FSM=IDLE.
- Reset asserted mid-frame aborts the frame: tx goes high and busy goes low immediately (asynchronous).
- rdata is purely combinational and has no reset value of its own.

Decomposition:
- Shared package:
  - MMIO page constant 16'hFFFF.
  - Offset constants LED/CYCLE/UART_TX/UART_DIV.
  - UART state encoding (IDLE, START, DATA, STOP).
  - Lane-index constants.
- One sub-module: uart_tx_core.
  - Inputs: clk, rst_n, load, data[7:0], div[15:0].
  - Outputs: tx, busy.
  - Contains the FSM and the counters.
- The top level holds the RAM, decode, LED/CYCLE/DIV registers and the read mux.

Test Plan:
- Reset, then read 0xFFFF0000/0xFFFF000C -> 0x00000000 / 0x000001B2. uart_tx=1, uart_busy=0.
- Write 0x11223344 to 0x00000010 with we=4'b1111, then we=4'b0100 with wdata=0x00AA0000 -> read 0x00000010 returns 0x11AA3344. Address 0x00001010 (ADDR_W=10) aliases and returns the same value.
- Read 0xFFFF0004 on two cycles N apart -> difference equals N. Preload via a forced value of 0xFFFFFFFF -> next cycle reads 0.
- Set DIV=4, write 0xA5 to UART_TX:
  - busy rises at the load edge and stays high 40 cycles.
  - tx sequence per 4-cycle slot: 0,1,0,1,0,0,1,0,1,1.
  - A second write of 0x3C mid-frame is dropped; no second frame appears.
- DIV=0, write 0x00 -> frame lasts 10 cycles. Assert rst_n low at cycle 5 -> tx=1 and busy=0 immediately. After release, a new write is accepted.
- Write 0xFFFF0004 and 0xFFFF0020 -> no state change. 0xFFFF0020 reads 0. LED write with we=4'b1110 leaves led unchanged.
